// File: rtl/rst_seq_pkg.sv
// Shared state encoding and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_ASSERT   = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_RDY = 2'd1;
    localparam logic [STATE_W-1:0] ST_GAP      = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE     = 2'd3;

    // Domain index width; a single domain still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_counter.sv
// Loadable down-counter shared by the hold, stagger and timeout phases.
// Load wins over enable; the value saturates at zero, zero flag is combinational.
module rst_seq_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS resets in index order with hold, ready-ack and stagger; RST_SEQ_TIMEOUT_EN bounds the ready wait.
// Outputs registered, one edge after the deciding sample; domains stall release by holding DOM_RDY low.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOM_RDY,
    output logic [NUM_DOMAINS-1:0] DOM_RST,
    output logic                   ALL_DONE,
    output logic                   BUSY,
    output logic                   TIMEOUT_ERR
);

    localparam int               IDX_W   = idx_w(NUM_DOMAINS);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LD = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic [STATE_W-1:0] state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic               restart;
    logic               rdy_cur;
    logic               tmo_hit;
    logic               wait_exit;
    logic               cnt_load;
    logic               cnt_en;
    logic               cnt_zero;
    logic [CNT_W-1:0]   cnt_val;

    assign restart   = RST | SW_RST_REQ;
    assign rdy_cur   = DOM_RDY[idx];
    assign idx_nxt   = idx + 1'b1;
    assign tmo_hit   = TMO_EN && (state == ST_WAIT_RDY) && !rdy_cur && cnt_zero;
    assign wait_exit = rdy_cur | tmo_hit;

    // One counter serves every phase, so it is reloaded on each phase entry.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = HOLD_LD;
        cnt_en   = 1'b0;
        if (restart) begin
            cnt_load = 1'b1;
            cnt_val  = HOLD_LD;
        end else begin
            case (state)
                ST_ASSERT, ST_GAP: begin
                    if (cnt_zero) begin
                        cnt_load = TMO_EN;
                        cnt_val  = TMO_LD;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_WAIT_RDY: begin
                    if (wait_exit && (idx != LAST)) begin
                        cnt_load = 1'b1;
                        cnt_val  = STAG_LD;
                    end else begin
                        cnt_en = TMO_EN;
                    end
                end
                default: ;
            endcase
        end
    end

    rst_seq_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (CLK),
        .load    (cnt_load),
        .load_val(cnt_val),
        .en      (cnt_en),
        .zero    (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (restart) begin
            state    <= ST_ASSERT;
            idx      <= '0;
            DOM_RST  <= '1;
            ALL_DONE <= 1'b0;
            BUSY     <= 1'b1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt_zero) begin
                        DOM_RST[idx] <= 1'b0;
                        state        <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (wait_exit) begin
                        if (idx == LAST) begin
                            state    <= ST_DONE;
                            DOM_RST  <= '0;
                            ALL_DONE <= 1'b1;
                            BUSY     <= 1'b0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        idx              <= idx_nxt;
                        DOM_RST[idx_nxt] <= 1'b0;
                        state            <= ST_WAIT_RDY;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    logic tmo_err;

    always_ff @(posedge CLK) begin
        if (restart) begin
            tmo_err <= 1'b0;
        end else if (tmo_hit) begin
            tmo_err <= 1'b1;
        end
    end

    assign TIMEOUT_ERR = tmo_err;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: release times are planned arithmetically from per-domain ready delays.
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int HOLD = 4;
    localparam int STAG = 2;
    localparam int TMO  = 5;
    localparam int NEVER = 1000;

    logic         CLK = 1'b0;
    logic         RST;
    logic         SW_RST_REQ;
    logic [N-1:0] DOM_RDY;
    logic [N-1:0] DOM_RST;
    logic         ALL_DONE;
    logic         BUSY;
    logic         TIMEOUT_ERR;

    int vectors     = 0;
    int miscompares = 0;

    // d: cycles DOM_RDY[k] stays low after domain k is released.
    // rel/pr: edge (counted from the restart edge) of release / of leaving the ready wait.
    int d  [N];
    int rel[N];
    int pr [N];
    int done_t;
    int err_t;

    always #5 CLK = ~CLK;

    reset_sequencer #(
        .NUM_DOMAINS   (N),
        .HOLD_CYCLES   (HOLD),
        .STAGGER_CYCLES(STAG),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .DOM_RDY    (DOM_RDY),
        .DOM_RST    (DOM_RST),
        .ALL_DONE   (ALL_DONE),
        .BUSY       (BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic plan();
        err_t  = 1 << 30;
        rel[0] = HOLD;
        for (int k = 0; k < N; k++) begin
`ifdef RST_SEQ_TIMEOUT_EN
            if (d[k] + 1 > TMO) begin
                pr[k] = rel[k] + TMO;
                if (pr[k] < err_t) err_t = pr[k];
            end else begin
                pr[k] = rel[k] + d[k] + 1;
            end
`else
            pr[k] = rel[k] + d[k] + 1;
`endif
            if (k < N - 1) rel[k+1] = pr[k] + STAG;
        end
        done_t = pr[N-1];
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".dom_rst"}, 16'(DOM_RST), 16'((1 << N) - 1));
        chk({tag, ".all_done"}, 16'(ALL_DONE), 16'd0);
        chk({tag, ".busy"}, 16'(BUSY), 16'd1);
        chk({tag, ".timeout_err"}, 16'(TIMEOUT_ERR), 16'd0);
    endtask

    // Restart by RST and/or SW_RST_REQ with random ready noise, which must be ignored.
    task automatic do_reset(input logic use_rst, input logic use_sw);
        RST        = use_rst;
        SW_RST_REQ = use_sw;
        DOM_RDY    = N'($urandom);
        @(posedge CLK);
        #1;
        check_reset_state(use_rst ? "rst" : "sw_rst");
        RST        = 1'b0;
        SW_RST_REQ = 1'b0;
    endtask

    // Run one sequence from the last restart edge; sw_at>0 pulses SW_RST_REQ at that edge and stops.
    task automatic run(input int sw_at);
        int           limit;
        logic [N-1:0] exp_rst;
        plan();
        limit = (done_t + 3 < 60) ? done_t + 3 : 60;
        for (int t = 1; t <= limit; t++) begin
            for (int k = 0; k < N; k++) begin
                if (t > rel[k] && t <= pr[k])
                    DOM_RDY[k] = (t >= rel[k] + 1 + d[k]);
                else
                    DOM_RDY[k] = 1'($urandom);
            end
            SW_RST_REQ = (t == sw_at);
            @(posedge CLK);
            #1;
            SW_RST_REQ = 1'b0;
            if (t == sw_at) begin
                check_reset_state("sw_mid");
                return;
            end
            for (int k = 0; k < N; k++) exp_rst[k] = (t < rel[k]);
            chk("dom_rst", 16'(DOM_RST), 16'(exp_rst));
            chk("all_done", 16'(ALL_DONE), 16'(t >= done_t));
            chk("busy", 16'(BUSY), 16'(t < done_t));
            chk("timeout_err", 16'(TIMEOUT_ERR), 16'(t >= err_t));
        end
    endtask

    initial begin
        RST        = 1'b1;
        SW_RST_REQ = 1'b0;
        DOM_RDY    = '0;
        repeat (2) @(posedge CLK);
        #1;
        do_reset(1'b1, 1'b0);

        // Ready acknowledged immediately by every domain.
        d = '{0, 0, 0};
        run(0);

        // Domain 1 slow to acknowledge.
        do_reset(1'b1, 1'b0);
        d = '{0, 10, 0};
        run(0);

        // Software restart in the stagger gap after domain 0, then a full rerun.
        do_reset(1'b1, 1'b0);
        d = '{0, 0, 0};
        plan();
        run(pr[0] + 1);
        run(0);

        // RST and SW_RST_REQ together in DONE, then SW_RST_REQ alone in DONE.
        do_reset(1'b1, 1'b1);
        d = '{1, 2, 0};
        run(0);
        do_reset(1'b0, 1'b1);
        d = '{3, 0, 2};
        run(0);

        // Delays straddling the timeout boundary.
        do_reset(1'b1, 1'b0);
        d = '{4, 5, 3};
        run(0);

        // Ready never arrives: timeout walk-through, or a permanent stall.
        do_reset(1'b1, 1'b0);
        d = '{NEVER, NEVER, NEVER};
        run(0);
        do_reset(1'b0, 1'b1);

        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < N; k++) d[k] = $urandom_range(0, 7);
            plan();
            if ($urandom_range(0, 2) == 0) begin
                run($urandom_range(1, done_t));
                run(0);
            end else begin
                run(0);
            end
            do_reset(1'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
